stage_controller: RTL and testbench
===================================

Name: stage_controller

Overview:
Consumes the one-hot 5-stage tick (IF=10000, ID=01000, EX=00100, MEM=00010, WB=00001) and issues per-stage control strobes for the multi-cycle core. It latches the instruction, decodes its class, and runs the memory req/ack handshake. While a memory access is outstanding it drives a combinational stall back to the tick source, which holds tick at MEM. It also checks tick legality and counts retired instructions.

Parameters:
INSTR_W, 16, instruction width; opcode = instr[INSTR_W-1 -: 4]
TIMEOUT, 8, max cycles mem_req may wait for mem_ack (>=1)
CNT_W, 16, retired_count width

Ports:
clk  in  1  clock; all state on posedge
rst_n  in  1  synchronous active-low reset
tick  in  5  one-hot stage tick from tick source
instr_in  in  INSTR_W  instruction word, valid while tick==IF
branch_taken  in  1  ALU branch condition, valid while tick==EX
mem_ack  in  1  memory completion
stall  out  1  combinational; tick source must hold tick while high
ir  out  INSTR_W  latched instruction register
ir_load  out  1  registered pulse: IF handled
rf_read_en  out  1  registered pulse: ID handled
alu_en  out  1  registered pulse: EX handled, ALU class only
mem_req  out  1  registered; high until ack or timeout
mem_we  out  1  registered; 1 for STORE, valid with mem_req
rf_we  out  1  registered pulse at WB: ALU or LOAD without timeout
pc_inc  out  1  registered pulse at WB: not taken jump/branch
pc_load  out  1  registered pulse at WB: JUMP, or BRANCH taken
retire  out  1  registered pulse at every handled WB
retired_count  out  CNT_W  wrapping count of retire pulses
illegal_op  out  1  registered pulse at ID for undefined opcode
mem_timeout  out  1  registered pulse when TIMEOUT expires
seq_err  out  1  registered pulse on illegal tick

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0, ir=0, count=0, internal class=NOP, mem_done=0, state=RESYNC. Reset overrides everything, including an access in flight: mem_req drops the next cycle, no timeout is flagged.
- States: RESYNC (wait for IF), RUN. In RESYNC only tick==IF is accepted: enter RUN, handle as IF. Any other tick in RESYNC is ignored silently.
- RUN legality: the sampled tick must equal rotate-right of the previous sampled tick (WB->IF wraps). Repeating MEM is also legal when stall was high in the previous cycle. Zero-hot, multi-hot or out-of-order tick -> seq_err pulse, no strobes, mem_req cleared, state=RESYNC.
- Strobes are asserted at the edge that samples the tick, so they are visible one cycle after the tick.
- IF: ir<=instr_in, ir_load=1, mem_done<=0.
- ID: rf_read_en=1. Opcode decode:
  - 0000-0111 ALU
  - 1000 LOAD
  - 1001 STORE
  - 1010 BRANCH
  - 1011 JUMP
  - 1111 NOP
  - else illegal_op=1 and class=NOP.
- EX: alu_en=1 if ALU; take_reg<=branch_taken.
- MEM, LOAD/STORE only:
  - stall = (tick==MEM) & mem_class & !mem_done. Combinational, high in the first MEM cycle.
  - First MEM edge: mem_req<=1, mem_we<=(STORE), wait counter<=0.
  - Each edge with mem_req=1: if mem_ack, then mem_req<=0 and mem_done<=1.
  - Else the counter increments. When it reaches TIMEOUT: mem_req<=0, mem_done<=1, mem_timeout=1, timed_out<=1.
  - mem_ack while mem_req=0 is ignored.
  - Other classes do not stall at MEM.
- WB:
  - retire=1 and retired_count+1 (wraps to 0).
  - rf_we for ALU, or LOAD with !timed_out.
  - pc_load for JUMP, or BRANCH with take_reg.
  - pc_inc otherwise, including NOP/illegal.
  - timed_out is cleared.
- Exactly one of pc_inc/pc_load is asserted per WB.

Test Plan:
- ALU: rst_n low 2 cycles then high; tick IF..WB with instr 0x1234 -> ir=0x1234, ir_load/rf_read_en/alu_en/rf_we/pc_inc/retire each pulse once; stall stays 0; retired_count=1.
- LOAD: instr 0x8000, mem_ack arrives 3 cycles after mem_req rises, tick held at MEM while stall=1 -> mem_req high exactly 3 cycles, mem_we=0, stall falls the cycle after ack, WB gives rf_we=1, pc_inc=1.
- STORE timeout (TIMEOUT=8): instr 0x9000, no ack -> mem_we=1, mem_req drops after 8 waiting edges with mem_timeout pulse, WB rf_we=0, pc_inc=1.
- Branch/jump: 0xA000 with branch_taken=1 -> pc_load=1, pc_inc=0. 0xA000 with branch_taken=0 -> pc_inc=1. 0xB000 -> pc_load=1. Opcode 0xC -> illegal_op at ID, then pc_inc=1, rf_we=0.
- Sequence: tick IF, ID, MEM (EX skipped) -> seq_err pulse, no strobes; subsequent WB ignored. Next IF resumes normal handling. Tick 5'b00110 -> seq_err.
- Reset mid-MEM: rst_n low while mem_req=1 -> next cycle all outputs 0, no mem_timeout, count=0. The first tick after release must be IF, and earlier ticks produce no strobes and no seq_err.

Source files
------------

// File: rtl/stage_controller.sv
// rtl/stage_controller.sv - per-stage control strobes, memory handshake and tick checking
// Turns the one-hot stage tick into registered strobes and stalls the tick source during memory access.
module stage_controller #(
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [4:0]         i_tick,
  input  logic [INSTR_W-1:0] i_instr_in,
  input  logic               i_branch_taken,
  input  logic               i_mem_ack,
  output logic               o_stall,
  output logic [INSTR_W-1:0] o_ir,
  output logic               o_ir_load,
  output logic               o_rf_read_en,
  output logic               o_alu_en,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic               o_rf_we,
  output logic               o_pc_inc,
  output logic               o_pc_load,
  output logic               o_retire,
  output logic [CNT_W-1:0]   o_retired_count,
  output logic               o_illegal_op,
  output logic               o_mem_timeout,
  output logic               o_seq_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [4:0] T_IF  = 5'b10000;
  localparam logic [4:0] T_ID  = 5'b01000;
  localparam logic [4:0] T_EX  = 5'b00100;
  localparam logic [4:0] T_MEM = 5'b00010;
  localparam logic [4:0] T_WB  = 5'b00001;

  typedef enum logic {S_RESYNC, S_RUN} state_t;
  typedef enum logic [2:0] {C_NOP, C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP} class_t;

  state_t             r_state, w_state_nxt;
  class_t             r_class, w_class_nxt;
  logic [4:0]         r_prev_tick, w_prev_tick_nxt;
  logic               r_stall_q;
  logic [INSTR_W-1:0] r_ir, w_ir_nxt;
  logic               r_mem_done, w_mem_done_nxt;
  logic               r_take, w_take_nxt;
  logic               r_timed_out, w_timed_out_nxt;
  logic [TW-1:0]      r_wait_cnt, w_wait_cnt_nxt, w_wait_inc;
  logic               r_mem_req, w_mem_req_nxt;
  logic               r_mem_we, w_mem_we_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;

  logic r_ir_load, w_ir_load_nxt;
  logic r_rf_read_en, w_rf_read_en_nxt;
  logic r_alu_en, w_alu_en_nxt;
  logic r_rf_we, w_rf_we_nxt;
  logic r_pc_inc, w_pc_inc_nxt;
  logic r_pc_load, w_pc_load_nxt;
  logic r_retire, w_retire_nxt;
  logic r_illegal_op, w_illegal_op_nxt;
  logic r_mem_timeout, w_mem_timeout_nxt;
  logic r_seq_err, w_seq_err_nxt;

  logic [3:0] w_opcode;
  logic [4:0] w_rot;
  logic       w_legal;
  logic       w_mem_class;
  logic       w_accept;

  assign w_opcode    = r_ir[INSTR_W-1 -: 4];
  assign w_rot       = {r_prev_tick[0], r_prev_tick[4:1]};
  assign w_mem_class = (r_class == C_LOAD) || (r_class == C_STORE);
  assign w_wait_inc  = r_wait_cnt + 1'b1;

  // A held MEM is only legal while the source was being told to hold it.
  assign w_legal = (i_tick == w_rot) ||
                   ((i_tick == T_MEM) && (r_prev_tick == T_MEM) && r_stall_q);

  // Gated by RUN so an aborted access can never freeze the tick source.
  assign o_stall = (r_state == S_RUN) && (i_tick == T_MEM) && w_mem_class && !r_mem_done;

  always_comb begin
    w_state_nxt       = r_state;
    w_prev_tick_nxt   = r_prev_tick;
    w_ir_nxt          = r_ir;
    w_class_nxt       = r_class;
    w_mem_done_nxt    = r_mem_done;
    w_take_nxt        = r_take;
    w_timed_out_nxt   = r_timed_out;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_mem_req_nxt     = r_mem_req;
    w_mem_we_nxt      = r_mem_we;
    w_count_nxt       = r_count;
    w_ir_load_nxt     = 1'b0;
    w_rf_read_en_nxt  = 1'b0;
    w_alu_en_nxt      = 1'b0;
    w_rf_we_nxt       = 1'b0;
    w_pc_inc_nxt      = 1'b0;
    w_pc_load_nxt     = 1'b0;
    w_retire_nxt      = 1'b0;
    w_illegal_op_nxt  = 1'b0;
    w_mem_timeout_nxt = 1'b0;
    w_seq_err_nxt     = 1'b0;
    w_accept          = 1'b0;

    if (r_state == S_RESYNC) begin
      if (i_tick == T_IF) begin
        w_state_nxt = S_RUN;
        w_accept    = 1'b1;
      end
    end else if (w_legal) begin
      w_accept = 1'b1;
    end else begin
      w_seq_err_nxt = 1'b1;
      w_mem_req_nxt = 1'b0;
      w_state_nxt   = S_RESYNC;
    end

    if (w_accept) begin
      w_prev_tick_nxt = i_tick;
      if (r_mem_req) begin
        if (i_mem_ack) begin
          w_mem_req_nxt  = 1'b0;
          w_mem_done_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = w_wait_inc;
          if (w_wait_inc == TW'(TIMEOUT)) begin
            w_mem_req_nxt     = 1'b0;
            w_mem_done_nxt    = 1'b1;
            w_mem_timeout_nxt = 1'b1;
            w_timed_out_nxt   = 1'b1;
          end
        end
      end
      case (i_tick)
        T_IF: begin
          w_ir_nxt       = i_instr_in;
          w_ir_load_nxt  = 1'b1;
          w_mem_done_nxt = 1'b0;
        end
        T_ID: begin
          w_rf_read_en_nxt = 1'b1;
          if (!w_opcode[3]) begin
            w_class_nxt = C_ALU;
          end else begin
            case (w_opcode[2:0])
              3'b000:  w_class_nxt = C_LOAD;
              3'b001:  w_class_nxt = C_STORE;
              3'b010:  w_class_nxt = C_BRANCH;
              3'b011:  w_class_nxt = C_JUMP;
              3'b111:  w_class_nxt = C_NOP;
              default: begin
                w_class_nxt      = C_NOP;
                w_illegal_op_nxt = 1'b1;
              end
            endcase
          end
        end
        T_EX: begin
          w_alu_en_nxt = (r_class == C_ALU);
          w_take_nxt   = i_branch_taken;
        end
        T_MEM: begin
          if ((r_prev_tick != T_MEM) && w_mem_class) begin
            w_mem_req_nxt  = 1'b1;
            w_mem_we_nxt   = (r_class == C_STORE);
            w_wait_cnt_nxt = '0;
          end
        end
        T_WB: begin
          w_retire_nxt    = 1'b1;
          w_count_nxt     = r_count + 1'b1;
          w_rf_we_nxt     = (r_class == C_ALU) || ((r_class == C_LOAD) && !r_timed_out);
          w_pc_load_nxt   = (r_class == C_JUMP) || ((r_class == C_BRANCH) && r_take);
          w_pc_inc_nxt    = !((r_class == C_JUMP) || ((r_class == C_BRANCH) && r_take));
          w_timed_out_nxt = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_RESYNC;
      r_class       <= C_NOP;
      r_prev_tick   <= '0;
      r_stall_q     <= 1'b0;
      r_ir          <= '0;
      r_mem_done    <= 1'b0;
      r_take        <= 1'b0;
      r_timed_out   <= 1'b0;
      r_wait_cnt    <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_count       <= '0;
      r_ir_load     <= 1'b0;
      r_rf_read_en  <= 1'b0;
      r_alu_en      <= 1'b0;
      r_rf_we       <= 1'b0;
      r_pc_inc      <= 1'b0;
      r_pc_load     <= 1'b0;
      r_retire      <= 1'b0;
      r_illegal_op  <= 1'b0;
      r_mem_timeout <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_class       <= w_class_nxt;
      r_prev_tick   <= w_prev_tick_nxt;
      r_stall_q     <= o_stall;
      r_ir          <= w_ir_nxt;
      r_mem_done    <= w_mem_done_nxt;
      r_take        <= w_take_nxt;
      r_timed_out   <= w_timed_out_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_count       <= w_count_nxt;
      r_ir_load     <= w_ir_load_nxt;
      r_rf_read_en  <= w_rf_read_en_nxt;
      r_alu_en      <= w_alu_en_nxt;
      r_rf_we       <= w_rf_we_nxt;
      r_pc_inc      <= w_pc_inc_nxt;
      r_pc_load     <= w_pc_load_nxt;
      r_retire      <= w_retire_nxt;
      r_illegal_op  <= w_illegal_op_nxt;
      r_mem_timeout <= w_mem_timeout_nxt;
      r_seq_err     <= w_seq_err_nxt;
    end
  end

  assign o_ir            = r_ir;
  assign o_ir_load       = r_ir_load;
  assign o_rf_read_en    = r_rf_read_en;
  assign o_alu_en        = r_alu_en;
  assign o_mem_req       = r_mem_req;
  assign o_mem_we        = r_mem_we;
  assign o_rf_we         = r_rf_we;
  assign o_pc_inc        = r_pc_inc;
  assign o_pc_load       = r_pc_load;
  assign o_retire        = r_retire;
  assign o_retired_count = r_count;
  assign o_illegal_op    = r_illegal_op;
  assign o_mem_timeout   = r_mem_timeout;
  assign o_seq_err       = r_seq_err;

endmodule

// File: tb/tb_stage_controller.sv
// tb/tb_stage_controller.sv - scoreboard bench for stage_controller
// Driver acts as the tick source and feeds a stage-level reference model; a monitor pops and compares.
module tb_stage_controller;

  localparam int TIMEOUT = 8;
  localparam logic [4:0] T_IF  = 5'b10000;
  localparam logic [4:0] T_EX  = 5'b00100;
  localparam logic [4:0] T_MEM = 5'b00010;
  localparam logic [4:0] T_WB  = 5'b00001;

  typedef enum {K_NOP, K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JUMP} kind_t;

  typedef struct packed {
    logic        ir_load;
    logic        rf_read_en;
    logic        alu_en;
    logic        mem_req;
    logic        mem_we;
    logic        rf_we;
    logic        pc_inc;
    logic        pc_load;
    logic        retire;
    logic        illegal_op;
    logic        mem_timeout;
    logic        seq_err;
    logic        stall;
    logic [15:0] ir;
    logic [15:0] count;
  } rec_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  tick;
  logic [15:0] instr;
  logic        br;
  logic        ack;
  logic        stall;
  logic [15:0] ir;
  logic        ir_load, rf_read_en, alu_en, mem_req, mem_we, rf_we;
  logic        pc_inc, pc_load, retire, illegal_op, mem_timeout, seq_err;
  logic [15:0] retired_count;

  stage_controller #(.INSTR_W(16), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_instr_in(instr),
    .i_branch_taken(br), .i_mem_ack(ack), .o_stall(stall), .o_ir(ir),
    .o_ir_load(ir_load), .o_rf_read_en(rf_read_en), .o_alu_en(alu_en),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_rf_we(rf_we), .o_pc_inc(pc_inc),
    .o_pc_load(pc_load), .o_retire(retire), .o_retired_count(retired_count),
    .o_illegal_op(illegal_op), .o_mem_timeout(mem_timeout), .o_seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en, tb_done, force_chk;

  // Reference model: stage index 0..4 (IF..WB), -1 for a malformed tick.
  bit          m_run, m_prev_stall, m_done, m_take, m_to, m_req, m_we;
  int          m_prev, m_wait;
  kind_t       m_cls;
  logic [15:0] m_ir, m_count;
  rec_t        pend;
  bit          last_stall;
  int          hi_cnt, ack_delay;
  logic [15:0] cur_instr;
  logic        cur_br;

  function automatic int stage_of(input logic [4:0] t);
    if ($countones(t) != 1) return -1;
    for (int i = 0; i < 5; i++) if (t[4-i]) return i;
    return -1;
  endfunction

  function automatic logic [4:0] onehot(input int s);
    return 5'b10000 >> s;
  endfunction

  function automatic logic [4:0] bad_tick(input int s);
    logic [4:0] v;
    case ($urandom_range(0, 2))
      0:       v = 5'b00000;
      1:       v = 5'($urandom) | onehot(s) | onehot((s + 2) % 5);
      default: v = onehot((s + 1 + int'($urandom_range(1, 3))) % 5);
    endcase
    return v;
  endfunction

  function automatic bit is_active(input rec_t r);
    return r.ir_load | r.rf_read_en | r.alu_en | r.mem_req | r.rf_we | r.pc_inc |
           r.pc_load | r.retire | r.illegal_op | r.mem_timeout | r.seq_err | r.stall;
  endfunction

  task automatic model_reset();
    m_run = 0; m_prev_stall = 0; m_done = 0; m_take = 0; m_to = 0; m_req = 0; m_we = 0;
    m_prev = 0; m_wait = 0; m_cls = K_NOP; m_ir = '0; m_count = '0;
  endtask

  function automatic bit model_stall(input logic [4:0] t);
    return m_run && (stage_of(t) == 3) && (m_cls == K_LOAD || m_cls == K_STORE) && !m_done;
  endfunction

  task automatic model_edge(input logic [4:0] t, input logic rv, input logic [15:0] ins,
                            input logic b, input logic a, input bit st);
    rec_t nx;
    int   idx;
    bit   ok, to_before;
    nx = '0;
    if (!rv) begin
      model_reset();
    end else begin
      idx = stage_of(t);
      ok  = 0;
      to_before = m_to;
      if (!m_run) begin
        if (idx == 0) begin m_run = 1; ok = 1; end
      end else if (idx >= 0 && (idx == (m_prev + 1) % 5 || (idx == 3 && m_prev == 3 && m_prev_stall))) begin
        ok = 1;
      end else begin
        nx.seq_err = 1; m_req = 0; m_run = 0;
      end
      if (ok) begin
        if (m_req) begin
          if (a) begin m_req = 0; m_done = 1; end
          else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin m_req = 0; m_done = 1; nx.mem_timeout = 1; m_to = 1; end
          end
        end
        case (idx)
          0: begin m_ir = ins; nx.ir_load = 1; m_done = 0; end
          1: begin
            nx.rf_read_en = 1;
            if (m_ir[15:12] < 4'd8) m_cls = K_ALU;
            else case (m_ir[15:12])
              4'd8:  m_cls = K_LOAD;
              4'd9:  m_cls = K_STORE;
              4'd10: m_cls = K_BRANCH;
              4'd11: m_cls = K_JUMP;
              4'd15: m_cls = K_NOP;
              default: begin m_cls = K_NOP; nx.illegal_op = 1; end
            endcase
          end
          2: begin nx.alu_en = (m_cls == K_ALU); m_take = b; end
          3: if (m_prev != 3 && (m_cls == K_LOAD || m_cls == K_STORE)) begin
               m_req = 1; m_we = (m_cls == K_STORE); m_wait = 0;
             end
          default: begin
            nx.retire  = 1;
            m_count    = m_count + 16'd1;
            nx.rf_we   = (m_cls == K_ALU) || (m_cls == K_LOAD && !to_before);
            nx.pc_load = (m_cls == K_JUMP) || (m_cls == K_BRANCH && m_take);
            nx.pc_inc  = !nx.pc_load;
            m_to = 0;
          end
        endcase
        m_prev = idx;
      end
      m_prev_stall = st;
    end
    nx.mem_req = m_req;
    nx.mem_we  = m_req & m_we;
    nx.ir      = m_ir;
    nx.count   = m_count;
    pend = nx;
  endtask

  // One clock of tick-source activity; the expectation for this cycle is queued before the model advances.
  task automatic step(input logic [4:0] t, input logic rv, input logic frc);
    rec_t        r;
    logic        a, b;
    logic [15:0] ins;
    bit          st;
    @(posedge clk);
    #1;
    ins = (t == T_IF) ? cur_instr : 16'($urandom);
    b   = (t == T_EX) ? cur_br : 1'($urandom);
    if (pend.mem_req) begin hi_cnt++; a = (hi_cnt == ack_delay); end
    else begin hi_cnt = 0; a = ($urandom_range(0, 3) == 0); end
    rst_n = rv; tick = t; instr = ins; br = b; ack = a;
    st = model_stall(t);
    last_stall = st;
    force_chk = frc || ($urandom_range(0, 7) == 0);
    r = pend;
    r.stall = st;
    if (is_active(r) || force_chk) sb.push_back(r);
    model_edge(t, rv, ins, b, a, st);
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic b, input int ad,
                           input int err_slot, input logic [4:0] err_tk);
    logic [4:0] t;
    cur_instr = ins; cur_br = b; ack_delay = ad;
    for (int s = 0; s < 5; s++) begin
      t = (s == err_slot) ? err_tk : onehot(s);
      step(t, 1'b1, 1'b0);
      if (s == 3) for (int k = 0; k < 40 && last_stall; k++) step(T_MEM, 1'b1, 1'b0);
    end
  endtask

  task automatic mem_reset(input logic [15:0] ins, input int hold);
    cur_instr = ins; cur_br = 0; ack_delay = 0;
    for (int s = 0; s < 4; s++) step(onehot(s), 1'b1, 1'b0);
    for (int k = 0; k < hold; k++) step(T_MEM, 1'b1, 1'b0);
    step(T_MEM, 1'b0, 1'b0);
    step(T_MEM, 1'b1, 1'b1);
    step(T_WB, 1'b1, 1'b1);
    step(5'b01000, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    rec_t a, e;
    if (mon_en) begin
      a.ir_load = ir_load; a.rf_read_en = rf_read_en; a.alu_en = alu_en; a.mem_req = mem_req;
      a.mem_we = mem_we & mem_req; a.rf_we = rf_we; a.pc_inc = pc_inc; a.pc_load = pc_load;
      a.retire = retire; a.illegal_op = illegal_op; a.mem_timeout = mem_timeout;
      a.seq_err = seq_err; a.stall = stall; a.ir = ir; a.count = retired_count;
      if (is_active(a) || force_chk) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output t=%0t got=%h want=nothing", $time, a);
        end else begin
          e = sb.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t got=%h want=%h", $time, a, e);
          end
        end
      end
    end
    if (tb_done) begin
      n_checks++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL missing_outputs got=0 want=%0d", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int op, sel;
    rst_n = 0; tick = '0; instr = '0; br = 0; ack = 0;
    mon_en = 0; tb_done = 0; force_chk = 0;
    pend = '0; hi_cnt = 0; ack_delay = 0; cur_instr = '0; cur_br = 0; last_stall = 0;
    model_reset();

    step(5'b0, 1'b0, 1'b0);
    mon_en = 1;
    step(5'b0, 1'b0, 1'b1);

    run_instr(16'h1234, 1'b0, 0, -1, 5'b0);
    run_instr(16'h8000, 1'b0, 3, -1, 5'b0);
    run_instr(16'h9000, 1'b0, 0, -1, 5'b0);
    run_instr(16'hA000, 1'b1, 0, -1, 5'b0);
    run_instr(16'hA000, 1'b0, 0, -1, 5'b0);
    run_instr(16'hB000, 1'b0, 0, -1, 5'b0);
    run_instr(16'hC000, 1'b0, 0, -1, 5'b0);
    run_instr(16'h1234, 1'b0, 0, 2, T_MEM);
    run_instr(16'h2345, 1'b0, 0, -1, 5'b0);
    run_instr(16'h1234, 1'b0, 0, 1, 5'b00110);
    mem_reset(16'h8000, 2);
    run_instr(16'h0F0F, 1'b0, 0, -1, 5'b0);

    for (int n = 0; n < 250; n++) begin
      op  = $urandom_range(0, 15);
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        run_instr({4'(op), 12'($urandom)}, 1'($urandom), $urandom_range(0, 11),
                  $urandom_range(0, 4), bad_tick(n % 5));
      end else if (sel == 1) begin
        mem_reset({3'b100, 1'($urandom), 12'($urandom)}, $urandom_range(0, 5));
      end else begin
        run_instr({4'(op), 12'($urandom)}, 1'($urandom), $urandom_range(0, 11), -1, 5'b0);
      end
    end

    step(5'b0, 1'b0, 1'b0);
    step(5'b0, 1'b1, 1'b1);
    step(5'b0, 1'b1, 1'b0);
    tb_done = 1;
  end

endmodule
